i2s_dac_tx: RTL and testbench
=============================

I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 Parameter: SAMPLE_W, default 16, bits per channel sample.
REQ-002 Parameter: MIN_BCLK_DIV, default 8, minimum clk cycles per BCLK period supported (documentation and assertion only).
REQ-003 Port: clk  input  1  system clock (48 MHz codec domain).
REQ-004 Port: rst  input  1  asynchronous active-low reset.
REQ-005 Port: bclk_in  input  1  codec bit clock (codec is master), asynchronous to clk.
REQ-006 Port: lrclk_in  input  1  codec frame clock (0 = left, 1 = right), asynchronous to clk.
REQ-007 Port: sample_left  input  SAMPLE_W  left sample, two's complement.
REQ-008 Port: sample_right  input  SAMPLE_W  right sample, two's complement.
REQ-009 Port: sample_valid  input  1  producer offers a stereo pair.
REQ-010 Port: sample_ready  output  1  one-entry holding buffer is empty.
REQ-011 Port: sdata_out  output  1  serial DAC data to codec.
REQ-012 Port: underrun  output  1  one-clk pulse when a frame starts with no pending pair.

Function
REQ-013 bclk_in and lrclk_in SHALL each pass through a 2-flop synchronizer; the BCLK falling edge is detected from the synchronized value (1 then 0), i.e. 3 clk after the pin edge.
REQ-014 The pair SHALL transfer into the holding buffer on a clk edge with sample_valid=1 and sample_ready=1; sample_ready = holding buffer empty.
REQ-015 States: IDLE, LEFT, RIGHT; IDLE drives sdata_out=0 until the first synchronized LRCLK 1->0 seen at a BCLK falling edge.
REQ-016 At each BCLK falling edge the block SHALL compare the synchronized LRCLK with its value at the previous BCLK falling edge; a change is a slot boundary.
REQ-017 At a 1->0 boundary (frame start): state -> LEFT, bit counter -> 0, holding buffer moves into the shift pair, and the buffer empties (sample_ready rises the next clk).
REQ-018 At a 0->1 boundary: state -> RIGHT, bit counter -> 0, right word from the shift pair is loaded.
REQ-019 On the boundary falling edge sdata_out SHALL be 0 (I2S one-bit delay); on falling edge k=1..SAMPLE_W of the slot it SHALL be bit SAMPLE_W-k (MSB first); beyond SAMPLE_W it SHALL be 0.
REQ-020 The bit counter SHALL saturate at SAMPLE_W+1 and never wrap; any slot length (16, 24, 32 BCLKs) SHALL be tolerated.
REQ-021 sdata_out SHALL be registered and change only on the clk following a detected BCLK falling edge.
REQ-022 If the buffer is empty at frame start, underrun SHALL pulse once and the frame uses the underrun data per REQ-027/028.
REQ-023 A transfer in the same clk as a frame start SHALL NOT feed the starting frame; it is held for the next frame, and the current frame counts as an underrun.
REQ-024 A 1->0 LRCLK change while in LEFT (missed right slot) SHALL be treated as a normal frame start.

Reset
REQ-025 rst=0 SHALL asynchronously force: state IDLE, synchronizers 0, buffer empty, shift pair 0, bit counter 0, sdata_out 0, sample_ready 0, underrun 0.
REQ-026 sample_ready SHALL rise on the first clk after rst deasserts; reset mid-frame discards the buffer and shift pair, and output resumes only at the next frame start.

Configuration
REQ-027 With macro I2S_TX_HOLD_LAST_EN defined, an underrun frame SHALL retransmit the last transmitted pair (0 if none since reset).
REQ-028 Without I2S_TX_HOLD_LAST_EN, an underrun frame SHALL transmit all zeros (silence); underrun pulses in both builds.

Verification
REQ-029 BCLK = clk/16, 32-bit slots, pair L=16'hA5C3, R=16'h0F0F offered before frame start -> sdata_out serial stream 0,1010010111000011,0... then 0,0000111100001111,0...; underrun stays 0.
REQ-030 No pair offered for frame 2 after L=16'h8001 -> underrun pulses once; build with I2S_TX_HOLD_LAST_EN repeats 16'h8001, build without emits 32 zero bits per slot.
REQ-031 sample_valid held 1 continuously -> exactly one transfer per frame, sample_ready low from transfer until the next frame start.
REQ-032 Transfer in the same clk as a frame start -> that frame is underrun; the pair appears in the following frame.
REQ-033 rst pulsed low mid-LEFT slot -> sdata_out 0 within the same cycle, sample_ready 1 on the first clk after release, output idle until the next LRCLK 1->0.
REQ-034 16-BCLK slots with SAMPLE_W=16 -> all 16 bits are sent with no truncation, and the LSB lands on the next slot's boundary edge.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// I2S transmitter (codec is bus master) with a one-pair holding buffer and underrun flagging.
// Define I2S_TX_HOLD_LAST_EN to repeat the last pair on underrun; otherwise silence is sent.
module i2s_dac_tx #(
   parameter int unsigned SAMPLE_W     = 16,
   parameter int unsigned MIN_BCLK_DIV = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bclk_in,
   input  logic                lrclk_in,
   input  logic [SAMPLE_W-1:0] sample_left,
   input  logic [SAMPLE_W-1:0] sample_right,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                sdata_out,
   output logic                underrun
);

   localparam int unsigned CNT_W = $clog2(SAMPLE_W + 2);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SAMPLE_W + 1);
   localparam logic [CNT_W-1:0] CNT_BITS = CNT_W'(SAMPLE_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_W - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LEFT  = 2'd1;
   localparam logic [1:0] ST_RIGHT = 2'd2;

   logic [1:0]          state, state_nx;
   logic                bclk_s1, bclk_s2, bclk_d;
   logic                lr_s1, lr_s2, lr_prev;
   logic [SAMPLE_W-1:0] buf_l, buf_r;
   logic                buf_full, buf_full_nx;
   logic [SAMPLE_W-1:0] pair_l, pair_l_nx, pair_r, pair_r_nx;
   logic [SAMPLE_W-1:0] sh, sh_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic                sdata_nx, underrun_nx;

   logic bclk_fall_c, frame_start_c, lr_rise_c, xfer_c;

   assign bclk_fall_c   = bclk_d & ~bclk_s2;
   assign frame_start_c = bclk_fall_c & ~lr_s2 & lr_prev;
   assign lr_rise_c     = bclk_fall_c & lr_s2 & ~lr_prev;
   assign xfer_c        = sample_valid & sample_ready;

   // Slot sequencing and serializer; a transfer landing on a frame start stays buffered.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      sh_nx       = sh;
      pair_l_nx   = pair_l;
      pair_r_nx   = pair_r;
      sdata_nx    = sdata_out;
      underrun_nx = 1'b0;
      buf_full_nx = xfer_c | (buf_full & ~frame_start_c);

      if (bclk_fall_c) begin
         sdata_nx = 1'b0;
         if (frame_start_c || (lr_rise_c && state != ST_IDLE)) begin
            // With slots exactly SAMPLE_W long the LSB is still pending here
            if (state != ST_IDLE && cnt == CNT_LAST) sdata_nx = sh[SAMPLE_W-1];
            cnt_nx = '0;
            if (frame_start_c) begin
               state_nx = ST_LEFT;
               if (buf_full) begin
                  pair_l_nx = buf_l;
                  pair_r_nx = buf_r;
                  sh_nx     = buf_l;
               end else begin
                  underrun_nx = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                  sh_nx       = pair_l;
`else
                  pair_l_nx   = '0;
                  pair_r_nx   = '0;
                  sh_nx       = '0;
`endif
               end
            end else begin
               state_nx = ST_RIGHT;
               sh_nx    = pair_r;
            end
         end else if (state != ST_IDLE) begin
            if (cnt < CNT_BITS) begin
               sdata_nx = sh[SAMPLE_W-1];
               sh_nx    = {sh[SAMPLE_W-2:0], 1'b0};
            end
            if (cnt != CNT_SAT) cnt_nx = cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         bclk_s1      <= 1'b0;
         bclk_s2      <= 1'b0;
         bclk_d       <= 1'b0;
         lr_s1        <= 1'b0;
         lr_s2        <= 1'b0;
         lr_prev      <= 1'b0;
         buf_l        <= '0;
         buf_r        <= '0;
         buf_full     <= 1'b0;
         pair_l       <= '0;
         pair_r       <= '0;
         sh           <= '0;
         cnt          <= '0;
         sdata_out    <= 1'b0;
         sample_ready <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         bclk_s1      <= bclk_in;
         bclk_s2      <= bclk_s1;
         bclk_d       <= bclk_s2;
         lr_s1        <= lrclk_in;
         lr_s2        <= lr_s1;
         if (bclk_fall_c) lr_prev <= lr_s2;
         if (xfer_c) begin
            buf_l <= sample_left;
            buf_r <= sample_right;
         end
         buf_full     <= buf_full_nx;
         sample_ready <= ~buf_full_nx;
         state        <= state_nx;
         pair_l       <= pair_l_nx;
         pair_r       <= pair_r_nx;
         sh           <= sh_nx;
         cnt          <= cnt_nx;
         sdata_out    <= sdata_nx;
         underrun     <= underrun_nx;
      end
   end

`ifndef SYNTHESIS
   // BCLK period sanity check, allowing one cycle of synchronizer jitter
   logic [15:0] fall_gap;
   logic        seen_fall;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fall_gap  <= '0;
         seen_fall <= 1'b0;
      end else if (bclk_fall_c) begin
         if (seen_fall) assert (32'(fall_gap) + 32'd2 >= MIN_BCLK_DIV);
         fall_gap  <= '0;
         seen_fall <= 1'b1;
      end else if (fall_gap != 16'hFFFF) begin
         fall_gap <= fall_gap + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: codec-side BCLK/LRCLK generator, directed pairs, serial-slot scoreboard.
module tb_i2s_dac_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        bclk = 1'b1;
   logic        lrclk = 1'b1;
   logic [15:0] sl = '0;
   logic [15:0] sr = '0;
   logic        sv = 1'b0;
   logic        sample_ready, sdata_out, underrun;

   i2s_dac_tx #(.SAMPLE_W(16), .MIN_BCLK_DIV(8)) dut (
      .clk(clk), .rst(rst), .bclk_in(bclk), .lrclk_in(lrclk),
      .sample_left(sl), .sample_right(sr), .sample_valid(sv),
      .sample_ready(sample_ready), .sdata_out(sdata_out), .underrun(underrun)
   );

   always #5 clk = ~clk;

`ifdef I2S_TX_HOLD_LAST_EN
   localparam logic [15:0] F3L = 16'h8001, F3R = 16'h1234;
   localparam logic [15:0] F7L = 16'h5555, F7R = 16'h6666;
   localparam logic [15:0] F13L = 16'h1357, F13R = 16'h2468;
`else
   localparam logic [15:0] F3L = 16'h0000, F3R = 16'h0000;
   localparam logic [15:0] F7L = 16'h0000, F7R = 16'h0000;
   localparam logic [15:0] F13L = 16'h0000, F13R = 16'h0000;
`endif

   typedef struct {
      logic [15:0] w;
      logic        ur;
      int          len;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   ur_cnt = 0;
   int   xfer_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Codec master: BCLK = clk/16, LRCLK toggles on BCLK falling edges
   int   div = 0, bis = 0, slot_len = 32, next_slot_len = 32;
   event fs_ev;
   always @(negedge clk) begin
      div = (div + 1) % 16;
      if (div == 0) begin
         bclk = 1'b0;
         if (bis == slot_len - 1) begin
            bis = 0;
            lrclk = ~lrclk;
            if (!lrclk) begin
               slot_len = next_slot_len;
               -> fs_ev;
            end
         end else begin
            bis++;
         end
      end else if (div == 8) begin
         bclk = 1'b1;
      end
   end

   always @(posedge clk) begin
      if (underrun) ur_cnt++;
      if (sv && sample_ready && rst) xfer_cnt++;
   end

   // Monitor: bits sampled at BCLK rise, one slot = positions 1..len (last is next boundary)
   logic        mon_lr = 1'b1;
   bit          mon_on = 1'b0;
   logic [31:0] mon_col = '0;
   logic [31:0] mon_exp;
   exp_t        mon_cur;
   int          mon_snap = 0;
   always @(posedge bclk) begin
      if (lrclk != mon_lr) begin
         if (mon_on) begin
            mon_col = {mon_col[30:0], sdata_out};
            mon_exp = (mon_cur.len == 32) ? {mon_cur.w, 16'h0000} : {16'h0000, mon_cur.w};
            chk("slot_data", mon_col, mon_exp);
         end
         if (q.size() > 0) begin
            mon_cur = q.pop_front();
            mon_on  = 1'b1;
            mon_col = '0;
            chk("underrun_pulses", 32'(ur_cnt - mon_snap), 32'(mon_cur.ur));
         end else begin
            mon_on = 1'b0;
         end
         mon_snap = ur_cnt;
      end else if (mon_on) begin
         mon_col = {mon_col[30:0], sdata_out};
      end
      mon_lr = lrclk;
   end

   task automatic push_frame(input logic [15:0] l, input logic [15:0] r, input logic ur, input int len);
      q.push_back('{w: l, ur: ur, len: len});
      q.push_back('{w: r, ur: 1'b0, len: len});
   endtask

   // Returns on the falling clk edge after the pair has been accepted
   task automatic wait_taken();
      bit got = 1'b0;
      int i = 0;
      while (!got && i < 2000) begin
         if (sample_ready) got = 1'b1;
         @(negedge clk);
         i++;
      end
      chk("xfer_taken", 32'(got), 32'd1);
   endtask

   task automatic offer(input logic [15:0] l, input logic [15:0] r);
      @(negedge clk);
      sl = l; sr = r; sv = 1'b1;
      wait_taken();
      sv = 1'b0;
   endtask

   int xs = 0;
   int nz = 0;
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sdata", 32'(sdata_out), 32'd0);
      chk("rst_ready", 32'(sample_ready), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", 32'(sample_ready), 32'd1);
      offer(16'hA5C3, 16'h0F0F);

      @(fs_ev); push_frame(16'hA5C3, 16'h0F0F, 1'b0, 32);          // F1
      repeat (40) @(negedge clk);
      offer(16'h8001, 16'h1234);
      @(fs_ev); push_frame(16'h8001, 16'h1234, 1'b0, 32);          // F2
      @(fs_ev); push_frame(F3L, F3R, 1'b1, 32);                    // F3 underrun
      xs = xfer_cnt;
      repeat (40) @(negedge clk);
      sl = 16'h1111; sr = 16'h2222; sv = 1'b1;
      wait_taken();
      sl = 16'h3333; sr = 16'h4444;
      chk("ready_low_full", 32'(sample_ready), 32'd0);
      repeat (300) @(negedge clk);
      chk("ready_low_midframe", 32'(sample_ready), 32'd0);

      @(fs_ev);                                                    // F4
      chk("xfers_f3", 32'(xfer_cnt - xs), 32'd1);
      xs = xfer_cnt;
      push_frame(16'h1111, 16'h2222, 1'b0, 32);
      wait_taken();
      sl = 16'h5555; sr = 16'h6666;
      chk("ready_low_f4", 32'(sample_ready), 32'd0);
      @(fs_ev);                                                    // F5
      chk("xfers_f4", 32'(xfer_cnt - xs), 32'd1);
      push_frame(16'h3333, 16'h4444, 1'b0, 32);
      wait_taken();
      sv = 1'b0;
      @(fs_ev); push_frame(16'h5555, 16'h6666, 1'b0, 32);          // F6

      @(fs_ev); push_frame(F7L, F7R, 1'b1, 32);                    // F7: same-clk transfer
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("ready_before_start", 32'(sample_ready), 32'd1);
      sl = 16'h7777; sr = 16'h8888; sv = 1'b1;
      @(negedge clk);
      sv = 1'b0;
      chk("held_for_next", 32'(sample_ready), 32'd0);

      @(fs_ev); push_frame(16'h7777, 16'h8888, 1'b0, 32);          // F8
      repeat (40) @(negedge clk);
      next_slot_len = 16;
      offer(16'h9ABC, 16'hC001);
      @(fs_ev); push_frame(16'h9ABC, 16'hC001, 1'b0, 16);          // F9
      repeat (20) @(negedge clk);
      offer(16'h8421, 16'h7E5A);
      @(fs_ev); push_frame(16'h8421, 16'h7E5A, 1'b0, 16);          // F10

      @(fs_ev);                                                    // F11: reset mid-left
      repeat (100) @(negedge clk);
      rst = 1'b0; #1;
      chk("sdata_in_rst", 32'(sdata_out), 32'd0);
      chk("ready_in_rst", 32'(sample_ready), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rel", 32'(sample_ready), 32'd1);
      offer(16'h1357, 16'h2468);
      nz = 0;
      repeat (150) begin
         @(negedge clk);
         if (sdata_out) nz++;
      end
      chk("idle_quiet", 32'(nz), 32'd0);

      @(fs_ev); push_frame(16'h1357, 16'h2468, 1'b0, 16);          // F12
      @(fs_ev); push_frame(F13L, F13R, 1'b1, 16);                  // F13 underrun
      @(fs_ev);
      repeat (30) @(negedge clk);
      chk("sb_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
